// File: rtl/pipe_pkg.sv
// Shared definitions for the shift pipeline: mode encoding and width helpers
// used to size the tap select and fill counter ports.
package pipe_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_LOAD   = 2'b11
    } pipe_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single-stage pipe still needs a one-bit tap select port.
    function automatic int tap_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/shift_pipe_reg_if.sv
// Control, data and observation signals of the shift pipeline bundled as one
// interface; the master drives the controls, the slave is the pipeline.
interface shift_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TAP_W = tap_width(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic                   en;
    pipe_mode_e             mode;
    logic                   flush;
    logic [WIDTH-1:0]       d;
    logic                   d_valid;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic [TAP_W-1:0]       tap_sel;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [WIDTH-1:0]       tap_q;
    logic                   tap_valid;
    logic [WIDTH*DEPTH-1:0] stage_bus;
    logic [CNT_W-1:0]       fill_cnt;

    modport master (
        output en, mode, flush, d, d_valid, load_data, tap_sel,
        input  q, q_valid, tap_q, tap_valid, stage_bus, fill_cnt
    );

    modport slave (
        input  en, mode, flush, d, d_valid, load_data, tap_sel,
        output q, q_valid, tap_q, tap_valid, stage_bus, fill_cnt
    );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: a W-bit register with synchronous active-low reset,
// load enable and externally computed next value.
module pipe_stage #(
    parameter int          W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d_next,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/shift_pipe_reg.sv
// DEPTH x WIDTH register pipeline with per-stage valid, supporting hold,
// shift, rotate, parallel load and flush, plus a fill counter and tap mux.
module shift_pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic            clk,
    input logic            rst_n,
    shift_pipe_reg_if.slave bus
);

    localparam int TAP_W = tap_width(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    // Each stage word is {data, valid}; valid sits in bit 0.
    logic [WIDTH:0]   stage_q [DEPTH];
    logic             stage_en;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] fill_cnt_next;

    // Flush only touches valid bits, so it must still open the stage enables.
    assign stage_en = bus.flush | (bus.en & (bus.mode != MODE_HOLD));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            localparam int PREV = (gi == 0) ? DEPTH - 1 : gi - 1;

            logic [WIDTH:0] shift_src;
            logic [WIDTH:0] stage_next;

            if (gi == 0) begin : g_head
                assign shift_src = {bus.d, bus.d_valid};
            end else begin : g_body
                assign shift_src = stage_q[PREV];
            end

            always_comb begin
                stage_next = stage_q[gi];
                if (bus.flush) begin
                    stage_next[0] = 1'b0;
                end else begin
                    case (bus.mode)
                        MODE_SHIFT:  stage_next = shift_src;
                        MODE_ROTATE: stage_next = stage_q[PREV];
                        MODE_LOAD:   stage_next = {bus.load_data[gi*WIDTH +: WIDTH], 1'b1};
                        default:     stage_next = stage_q[gi];
                    endcase
                end
            end

            pipe_stage #(
                .W       (WIDTH + 1),
                .RST_VAL ({RESET_VAL, 1'b0})
            ) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (stage_en),
                .d_next (stage_next),
                .q      (stage_q[gi])
            );

            assign bus.stage_bus[gi*WIDTH +: WIDTH] = stage_q[gi][WIDTH:1];
        end
    endgenerate

    // Fill count tracks valid bits incrementally instead of a popcount tree.
    always_comb begin
        fill_cnt_next = fill_cnt_reg;
        if (bus.flush) begin
            fill_cnt_next = '0;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_SHIFT: fill_cnt_next = fill_cnt_reg + CNT_W'(bus.d_valid)
                                          - CNT_W'(stage_q[DEPTH-1][0]);
                MODE_LOAD:  fill_cnt_next = CNT_W'(DEPTH);
                default:    fill_cnt_next = fill_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt_reg <= '0;
        end else begin
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    // Out-of-range selects (non-power-of-two DEPTH) fall through to zero.
    always_comb begin
        bus.tap_q     = '0;
        bus.tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.tap_sel == TAP_W'(i)) begin
                bus.tap_q     = stage_q[i][WIDTH:1];
                bus.tap_valid = stage_q[i][0];
            end
        end
    end

    assign bus.q        = stage_q[DEPTH-1][WIDTH:1];
    assign bus.q_valid  = stage_q[DEPTH-1][0];
    assign bus.fill_cnt = fill_cnt_reg;

endmodule

// File: tb/tb_shift_pipe_reg.sv
// Directed bench for shift_pipe_reg: a DEPTH=4 and a DEPTH=3 instance driven
// with hand-computed vectors, plus a tap-sweep popcount check after every edge.
module tb_shift_pipe_reg;
    import pipe_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    shift_pipe_reg_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    shift_pipe_reg_if #(.WIDTH(8), .DEPTH(3)) ifb ();

    shift_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    shift_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Advance one edge on dut_a, then sweep the tap to confirm fill_cnt equals
    // the number of set valid bits.
    task automatic step_a(input string tag);
        logic [1:0] saved;
        int         cnt;
        @(posedge clk);
        #1;
        saved = ifa.tap_sel;
        cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            ifa.tap_sel = 2'(i);
            #1;
            cnt += int'(ifa.tap_valid);
        end
        ifa.tap_sel = saved;
        #1;
        check_val({tag, "_pop"}, 64'(ifa.fill_cnt), 64'(cnt));
        $display("[TB] A %s: q=%h qv=%0d fill=%0d bus=%h", tag, ifa.q, ifa.q_valid,
                 ifa.fill_cnt, ifa.stage_bus);
    endtask

    task automatic step_b(input string tag);
        @(posedge clk);
        #1;
        $display("[TB] B %s: q=%h qv=%0d fill=%0d bus=%h", tag, ifb.q, ifb.q_valid,
                 ifb.fill_cnt, ifb.stage_bus);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        ifa.en = 1'b0; ifa.mode = MODE_HOLD; ifa.flush = 1'b0; ifa.d = '0;
        ifa.d_valid = 1'b0; ifa.load_data = '0; ifa.tap_sel = '0;
        ifb.en = 1'b0; ifb.mode = MODE_HOLD; ifb.flush = 1'b0; ifb.d = '0;
        ifb.d_valid = 1'b0; ifb.load_data = '0; ifb.tap_sel = '0;

        // 1. reset and latency
        step_a("rst1");
        step_a("rst2");
        check_val("rst_q", 64'(ifa.q), 64'h00);
        check_val("rst_qv", 64'(ifa.q_valid), 64'd0);
        check_val("rst_fill", 64'(ifa.fill_cnt), 64'd0);
        check_val("rst_tapv", 64'(ifa.tap_valid), 64'd0);
        rst_n = 1'b1;
        ifa.en = 1'b1; ifa.mode = MODE_SHIFT; ifa.d = 8'hA5; ifa.d_valid = 1'b1;
        step_a("lat1");
        ifa.d = 8'h00; ifa.d_valid = 1'b0;
        step_a("lat2");
        step_a("lat3");
        check_val("lat3_qv", 64'(ifa.q_valid), 64'd0);
        step_a("lat4");
        check_val("lat4_q", 64'(ifa.q), 64'hA5);
        check_val("lat4_qv", 64'(ifa.q_valid), 64'd1);
        step_a("lat5");
        check_val("lat5_qv", 64'(ifa.q_valid), 64'd0);
        check_val("lat5_fill", 64'(ifa.fill_cnt), 64'd0);

        // 2. full stream
        for (int k = 1; k <= 6; k++) begin
            ifa.d = 8'(k); ifa.d_valid = 1'b1;
            step_a($sformatf("stream%0d", k));
            check_val($sformatf("stream%0d_fill", k), 64'(ifa.fill_cnt),
                      64'((k < 4) ? k : 4));
            if (k == 4) check_val("stream4_q", 64'(ifa.q), 64'h01);
            if (k == 5) check_val("stream5_q", 64'(ifa.q), 64'h02);
        end
        check_val("stream6_bus", 64'(ifa.stage_bus), 64'h03040506);

        // 3. load then rotate
        ifa.d_valid = 1'b0; ifa.mode = MODE_LOAD; ifa.load_data = 32'h44332211;
        ifa.tap_sel = 2'd2;
        step_a("load");
        check_val("load_bus", 64'(ifa.stage_bus), 64'h44332211);
        check_val("load_q", 64'(ifa.q), 64'h44);
        check_val("load_fill", 64'(ifa.fill_cnt), 64'd4);
        check_val("load_tap", 64'(ifa.tap_q), 64'h33);
        check_val("load_tapv", 64'(ifa.tap_valid), 64'd1);
        ifa.mode = MODE_ROTATE; ifa.d = 8'hEE; ifa.d_valid = 1'b1;
        step_a("rot1");
        check_val("rot1_bus", 64'(ifa.stage_bus), 64'h33221144);
        check_val("rot1_q", 64'(ifa.q), 64'h33);
        check_val("rot1_fill", 64'(ifa.fill_cnt), 64'd4);
        step_a("rot2");
        step_a("rot3");
        step_a("rot4");
        check_val("rot4_bus", 64'(ifa.stage_bus), 64'h44332211);
        check_val("rot4_fill", 64'(ifa.fill_cnt), 64'd4);

        // 4. priority: flush over shift, reset over flush
        ifa.flush = 1'b1; ifa.mode = MODE_SHIFT; ifa.d = 8'hEE; ifa.d_valid = 1'b1;
        step_a("flush");
        check_val("flush_fill", 64'(ifa.fill_cnt), 64'd0);
        check_val("flush_qv", 64'(ifa.q_valid), 64'd0);
        check_val("flush_bus", 64'(ifa.stage_bus), 64'h44332211);
        rst_n = 1'b0;
        step_a("rstflush");
        check_val("rstflush_bus", 64'(ifa.stage_bus), 64'h00000000);
        check_val("rstflush_fill", 64'(ifa.fill_cnt), 64'd0);
        rst_n = 1'b1; ifa.flush = 1'b0;

        // 5. hold and stall with two valid entries
        ifa.d = 8'h10; ifa.d_valid = 1'b1;
        step_a("fill1");
        ifa.d = 8'h20;
        step_a("fill2");
        check_val("fill2_bus", 64'(ifa.stage_bus), 64'h00001020);
        check_val("fill2_fill", 64'(ifa.fill_cnt), 64'd2);
        ifa.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifa.d = (k % 2 == 0) ? 8'hFF : 8'h5A;
            ifa.d_valid = 1'(k % 2);
            step_a($sformatf("stall%0d", k));
            check_val($sformatf("stall%0d_bus", k), 64'(ifa.stage_bus), 64'h00001020);
            check_val($sformatf("stall%0d_fill", k), 64'(ifa.fill_cnt), 64'd2);
        end
        ifa.en = 1'b1; ifa.mode = MODE_HOLD; ifa.d = 8'hFF; ifa.d_valid = 1'b1;
        ifa.tap_sel = 2'd1;
        step_a("hold");
        check_val("hold_bus", 64'(ifa.stage_bus), 64'h00001020);
        check_val("hold_fill", 64'(ifa.fill_cnt), 64'd2);
        check_val("hold_tap", 64'(ifa.tap_q), 64'h10);
        check_val("hold_tapv", 64'(ifa.tap_valid), 64'd1);
        ifa.mode = MODE_SHIFT; ifa.d = 8'h30; ifa.d_valid = 1'b0;
        step_a("sh30");
        check_val("sh30_bus", 64'(ifa.stage_bus), 64'h00102030);
        check_val("sh30_fill", 64'(ifa.fill_cnt), 64'd2);
        ifa.d = 8'h40;
        step_a("sh40");
        check_val("sh40_q", 64'(ifa.q), 64'h10);
        check_val("sh40_qv", 64'(ifa.q_valid), 64'd1);
        ifa.d = 8'h50; ifa.d_valid = 1'b1;
        step_a("sh50");
        check_val("sh50_bus", 64'(ifa.stage_bus), 64'h20304050);
        check_val("sh50_fill", 64'(ifa.fill_cnt), 64'd2);
        ifa.en = 1'b0;

        // 6. DEPTH=3 instance
        ifb.en = 1'b1; ifb.mode = MODE_SHIFT; ifb.tap_sel = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            ifb.d = 8'(k + 6); ifb.d_valid = 1'b1;
            step_b($sformatf("b%0d", k));
            check_val($sformatf("b%0d_fill", k), 64'(ifb.fill_cnt), 64'((k < 3) ? k : 3));
            check_val($sformatf("b%0d_tap3", k), 64'(ifb.tap_q), 64'h00);
            check_val($sformatf("b%0d_tap3v", k), 64'(ifb.tap_valid), 64'd0);
        end
        check_val("b4_q", 64'(ifb.q), 64'h08);
        ifb.tap_sel = 2'd2;
        #1;
        check_val("b4_tap2", 64'(ifb.tap_q), 64'h08);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
